// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan reader.
//   - default values for the block parameters
//   - segment patterns of the sixteen hex glyphs (seg[6:0] = g,f,e,d,c,b,a)
//   - capture FSM state encoding
package seg7_pkg;

  localparam int DEF_NUM_DIGITS     = 4;
  localparam int DEF_STABLE_CYCLES  = 8;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // IDLE  : no single digit selected (blank or several enables low)
  // SETTLE: one digit selected, waiting for the pattern to stay put
  // HELD  : digit captured, waiting for the bus to move on
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Frame output bundle of the scan reader.
//   value       : decoded frame, digit i in value[4i+3:4i]
//   digit_err   : bit i set when digit i carried a non-glyph pattern
//   frame_valid : a published frame is waiting for the consumer
//   frame_ready : consumer accepts the frame this cycle
//   overrun     : sticky, a frame was dropped while one was pending
//   stale       : no frame published for the timeout period
// master = reader (drives the frame), slave = consumer.
interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = seg7_pkg::DEF_NUM_DIGITS
);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overrun;
  logic                    stale;

  modport master (
    output value,
    output digit_err,
    output frame_valid,
    output overrun,
    output stale,
    input  frame_ready
  );

  modport slave (
    input  value,
    input  digit_err,
    input  frame_valid,
    input  overrun,
    input  stale,
    output frame_ready
  );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment to hex nibble decoder.
//   seg    : segment pattern, active-high, seg[6:0] = g,f,e,d,c,b,a
//   nibble : hex value of the glyph (0 for unknown patterns)
//   valid  : 1 when seg is one of the sixteen hex glyphs
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Passive reader for a multiplexed 7-segment display bus.
// Watches the digit enables and segment lines driven to a display, captures
// each digit once its pattern has been steady long enough, and publishes a
// complete frame once every digit has been captured.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   an    : digit enables, active-low, an[i]=0 selects digit i
//   seg   : segment lines, active-high, seg[6:0] = g,f,e,d,c,b,a
//   fr    : frame output bundle (value, digit_err, frame_valid,
//           frame_ready, overrun, stale)
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] an,
  input  logic [6:0]            seg,
  seg7_scan_reader_if.master    fr
);

  localparam int CNT_W = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES + 1)  : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int IDX_W = (NUM_DIGITS     > 1) ? $clog2(NUM_DIGITS)         : 1;
  // With a one-cycle stability window the digit is captured on entry.
  localparam bit CAPTURE_ON_ENTRY = (STABLE_CYCLES <= 1);

  // True when exactly one enable is low.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] inv;
    inv = ~v;
    return (inv != '0) && ((inv & (inv - NUM_DIGITS'(1))) == '0);
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2 keeps the previous synchronized
  // sample so that any movement on the bus can be detected.
  logic [NUM_DIGITS-1:0] an_p0, an_p1, an_p2;
  logic [6:0]            seg_p0, seg_p1, seg_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p0  <= '1;
      an_p1  <= '1;
      an_p2  <= '1;
      seg_p0 <= '0;
      seg_p1 <= '0;
      seg_p2 <= '0;
    end else begin
      an_p0  <= an;
      an_p1  <= an_p0;
      an_p2  <= an_p1;
      seg_p0 <= seg;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
    end
  end

  logic changed;
  logic sel_one;
  assign changed = (an_p1 != an_p2) || (seg_p1 != seg_p2);
  assign sel_one = one_low(an_p1);

  // Stage p1 decode: glyph lookup and index of the selected digit.
  logic [3:0]       glyph_nib;
  logic             glyph_ok;
  logic [IDX_W-1:0] sel_idx;

  seg7_glyph_decode u_decode (
    .seg    (seg_p1),
    .nibble (glyph_nib),
    .valid  (glyph_ok)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_p1[i]) sel_idx = IDX_W'(i);
    end
  end

  // Capture FSM
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_one) begin
          state_d = CAPTURE_ON_ENTRY ? HELD : SETTLE;
          cnt_d   = CNT_W'(1);
          capture = CAPTURE_ON_ENTRY;
        end
      end
      SETTLE, HELD: begin
        if (changed) begin
          // Bus moved: restart the window on the new digit, or give up.
          if (sel_one) begin
            state_d = CAPTURE_ON_ENTRY ? HELD : SETTLE;
            cnt_d   = CNT_W'(1);
            capture = CAPTURE_ON_ENTRY;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (state_q == SETTLE) begin
          if (cnt_q >= CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = HELD;
            cnt_d   = CNT_W'(STABLE_CYCLES);
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage p2: shadow frame under construction. The mask tracks which digits
  // have been captured since the last publish; a full mask publishes on the
  // following edge. A capture landing on that same edge starts the next frame.
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   shadow_err_q;
  logic                    publish;

  assign publish = &mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= (publish ? '0 : mask_q) | (capture ? ~an_p1 : '0);
    end
  end

  // Shadow contents are only meaningful under the mask, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow_q[sel_idx*4 +: 4] <= glyph_nib;
      shadow_err_q[sel_idx]    <= ~glyph_ok;
    end
  end

  // Stage p3: published frame, handshake and supervision.
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   digit_err_q;
  logic                    vld_p3;
  logic                    overrun_q;
  logic                    stale_q;
  logic [TO_W-1:0]         to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      digit_err_q <= '0;
      vld_p3      <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (publish) begin
      if (!vld_p3 || fr.frame_ready) begin
        value_q     <= shadow_q;
        digit_err_q <= shadow_err_q;
        vld_p3      <= 1'b1;
        if (vld_p3) overrun_q <= 1'b0;
      end else begin
        // Consumer still holds the previous frame: keep it and flag the drop.
        overrun_q <= 1'b1;
      end
    end else if (vld_p3 && fr.frame_ready) begin
      vld_p3    <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  // Timeout counts from the last publish, accepted or dropped, and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b0;
    end else if (publish) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b0;
    end else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) stale_q <= 1'b1;
    end
  end

  assign fr.value       = value_q;
  assign fr.digit_err   = digit_err_q;
  assign fr.frame_valid = vld_p3;
  assign fr.overrun     = overrun_q;
  assign fr.stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Testbench for seg7_scan_reader: drives display scans digit by digit and
// compares the published frame against a frame-level reference model.
module tb_seg7_scan_reader;
  import seg7_pkg::*;

  localparam int N = 4;
  localparam int S = 8;
  localparam int T = 65535;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] an;
  logic [6:0]   seg;

  seg7_scan_reader_if #(.NUM_DIGITS(N)) fr_if ();

  seg7_scan_reader #(
    .NUM_DIGITS     (N),
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .an    (an),
    .seg   (seg),
    .fr    (fr_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: what the consumer should see, frame by frame.
  logic [3:0]     m_nib [N];
  logic [N-1:0]   m_serr;
  logic [N-1:0]   m_mask;
  logic [4*N-1:0] m_value;
  logic [N-1:0]   m_derr;
  logic           m_fv;
  logic           m_ovr;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (glyph_tab[i] == s) return {1'b0, 4'(i)};
    end
    return 5'h10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_stale);
    chk({tag, ".value"},       32'(fr_if.value),       32'(m_value));
    chk({tag, ".digit_err"},   32'(fr_if.digit_err),   32'(m_derr));
    chk({tag, ".frame_valid"}, 32'(fr_if.frame_valid), 32'(m_fv));
    chk({tag, ".overrun"},     32'(fr_if.overrun),     32'(m_ovr));
    chk({tag, ".stale"},       32'(fr_if.stale),       32'(exp_stale));
  endtask

  task automatic model_reset();
    m_mask  = '0;
    m_serr  = '0;
    m_value = '0;
    m_derr  = '0;
    m_fv    = 1'b0;
    m_ovr   = 1'b0;
    for (int i = 0; i < N; i++) m_nib[i] = 4'h0;
  endtask

  task automatic model_capture(input int d, input logic [6:0] s);
    logic [4:0] dec;
    dec       = ref_decode(s);
    m_nib[d]  = dec[3:0];
    m_serr[d] = dec[4];
    m_mask[d] = 1'b1;
    if (m_mask == '1) begin
      m_mask = '0;
      if (!m_fv || fr_if.frame_ready) begin
        for (int i = 0; i < N; i++) m_value[i*4 +: 4] = m_nib[i];
        m_derr = m_serr;
        if (m_fv) m_ovr = 1'b0;
        m_fv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  // Show one digit for cyc cycles, then blank the display briefly.
  task automatic hold(input int d, input logic [6:0] s, input int cyc);
    an  = ~(N'(1) << d);
    seg = s;
    repeat (cyc) @(negedge clk);
    an  = '1;
    seg = 7'h00;
    repeat (4) @(negedge clk);
    if (cyc >= S + 3) model_capture(d, s);
  endtask

  task automatic accept();
    fr_if.frame_ready = 1'b1;
    @(negedge clk);
    fr_if.frame_ready = 1'b0;
    if (m_fv) begin
      m_fv  = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(0, s0, 20);
    hold(1, s1, 20);
    hold(2, s2, 20);
    hold(3, s3, 20);
  endtask

  initial begin
    rst_n             = 1'b0;
    an                = '1;
    seg               = 7'h00;
    fr_if.frame_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic 1-2-3-4 scan, partial frame first
    hold(0, 7'h06, 20);
    hold(1, 7'h5B, 20);
    hold(2, 7'h4F, 20);
    check_all("partial", 1'b0);
    hold(3, 7'h66, 20);
    check_all("scan1234", 1'b0);
    chk("scan1234.literal", 32'(fr_if.value), 32'h4321);
    accept();
    check_all("scan1234.ack", 1'b0);

    // Every glyph on every digit
    for (int g = 0; g < 16; g++) begin
      scan4(glyph_tab[g], glyph_tab[g], glyph_tab[g], glyph_tab[g]);
      check_all($sformatf("sweep%0d", g), 1'b0);
      accept();
    end

    // Too-short hold on the last digit does not complete the frame
    hold(0, glyph_tab[7], 20);
    hold(1, glyph_tab[8], 20);
    hold(2, glyph_tab[9], 20);
    hold(3, glyph_tab[10], 5);
    check_all("short", 1'b0);
    hold(3, glyph_tab[11], 20);
    check_all("short.recover", 1'b0);
    accept();

    // Blank pattern on digit 2
    scan4(glyph_tab[5], glyph_tab[6], 7'h00, glyph_tab[12]);
    check_all("blankseg", 1'b0);
    chk("blankseg.err_literal", 32'(fr_if.digit_err), 32'h4);
    chk("blankseg.nib_literal", 32'(fr_if.value[11:8]), 32'h0);
    accept();

    // Two frames without acceptance: first one kept, overrun flagged
    scan4(glyph_tab[1], glyph_tab[3], glyph_tab[5], glyph_tab[7]);
    scan4(glyph_tab[2], glyph_tab[4], glyph_tab[6], glyph_tab[8]);
    check_all("overrun", 1'b0);
    chk("overrun.literal", 32'(fr_if.value), 32'h7531);
    accept();
    check_all("overrun.ack", 1'b0);

    // Randomized scans: random order, glyphs, raw patterns and hold lengths
    for (int r = 0; r < 12; r++) begin
      int off;
      off = $urandom_range(0, N - 1);
      for (int k = 0; k < N; k++) begin
        logic [6:0] s;
        int         cyc;
        if ($urandom_range(0, 3) == 0) s = 7'($urandom_range(0, 127));
        else                           s = glyph_tab[$urandom_range(0, 15)];
        cyc = ($urandom_range(0, 4) == 0) ? 5 : 20;
        hold((off + k) % N, s, cyc);
      end
      check_all($sformatf("rand%0d", r), 1'b0);
      if ($urandom_range(0, 1) == 1) accept();
    end
    accept();

    // Reset in the middle of a frame, with a pending frame and overrun set
    scan4(glyph_tab[9], glyph_tab[9], glyph_tab[9], glyph_tab[9]);
    scan4(glyph_tab[4], glyph_tab[4], glyph_tab[4], glyph_tab[4]);
    hold(0, glyph_tab[13], 20);
    hold(1, glyph_tab[14], 20);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_reset", 1'b0);
    repeat (3) @(negedge clk);
    check_all("in_reset", 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    hold(2, glyph_tab[2], 20);
    hold(3, glyph_tab[3], 20);
    check_all("post_reset.partial", 1'b0);
    hold(0, glyph_tab[0], 20);
    hold(1, glyph_tab[1], 20);
    check_all("post_reset.frame", 1'b0);
    chk("post_reset.literal", 32'(fr_if.value), 32'h3210);
    accept();

    // Idle display: stale only after the full timeout since the last publish
    repeat (65000) @(negedge clk);
    chk("stale.early", 32'(fr_if.stale), 32'h0);
    repeat (600) @(negedge clk);
    check_all("stale.late", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits observed.
REQ-002 Parameter STABLE_CYCLES, default 8: consecutive identical synchronized samples required before a digit is captured.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: cycles without a published frame before stale asserts.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 an  input  NUM_DIGITS  digit enables, active-low; an[i]=0 selects digit i.
REQ-007 seg  input  7  segment lines, active-high, seg[6:0]=g,f,e,d,c,b,a.
REQ-008 value  output  4*NUM_DIGITS  decoded frame; digit i in value[4i+3:4i].
REQ-009 digit_err  output  NUM_DIGITS  bit i set when digit i held a non-glyph pattern.
REQ-010 frame_valid  output  1  published frame available.
REQ-011 frame_ready  input  1  consumer accepts frame.
REQ-012 overrun  output  1  sticky; a frame was dropped while frame_valid was pending.
REQ-013 stale  output  1  no frame published within TIMEOUT_CYCLES.

Function
REQ-014 an and seg SHALL pass through a two-flop synchronizer before any use.
REQ-015 Glyph map (seg hex -> nibble) SHALL be 3F->0,06->1,5B->2,4F->3,66->4,6D->5,7D->6,07->7,7F->8,6F->9,77->A,7C->B,39->C,5E->D,79->E,71->F; any other pattern -> nibble 0 with error flag.
REQ-016 FSM states: IDLE, SETTLE, HELD.
REQ-017 IDLE -> SETTLE when synchronized an has exactly one low bit; stability counter loads 1.
REQ-018 SETTLE: counter increments while synchronized {an,seg} is unchanged; any change restarts counting (SETTLE if still one-hot-low, else IDLE).
REQ-019 SETTLE -> HELD on the edge where the counter reaches STABLE_CYCLES; that edge SHALL write the digit nibble and digit_err bit into the shadow buffer and set the digit's bit in the capture mask.
REQ-020 HELD -> SETTLE/IDLE on any change of synchronized {an,seg}; no recapture while unchanged.
REQ-021 an all-high (blank) or more than one low bit SHALL never capture.
REQ-022 Recapturing an already-masked digit SHALL overwrite its shadow entry.
REQ-023 When the mask becomes all-ones, the next edge SHALL publish: copy shadow to value/digit_err, clear mask, reload timeout counter.
REQ-024 Publish with frame_valid=0 or with frame_valid=1 and frame_ready=1 in the same cycle SHALL update value and set frame_valid=1.
REQ-025 Publish with frame_valid=1 and frame_ready=0 SHALL keep value unchanged, discard the new frame, and set overrun.
REQ-026 frame_valid SHALL clear on the edge where frame_valid=1 and frame_ready=1 with no simultaneous publish; overrun clears on that same handshake.
REQ-027 value and digit_err SHALL be stable whenever frame_valid=1.
REQ-028 stale SHALL set when the timeout counter reaches TIMEOUT_CYCLES since the last publish and clear on the next publish.
REQ-029 Input change to capture latency: 2 + STABLE_CYCLES cycles; capture to frame_valid: 1 cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force: value=0, digit_err=0, frame_valid=0, overrun=0, stale=0, FSM=IDLE, mask=0, counters=0, synchronizers=all-ones (an) / 0 (seg).
REQ-031 Reset mid-frame SHALL discard partial captures; first frame after reset requires all digits captured anew.

Structure
REQ-032 Package seg7_pkg SHALL hold the glyph constants, FSM state enum, and default parameter values.
REQ-033 Sub-module seg7_glyph_decode SHALL be combinational: seg in, nibble and valid out, implementing REQ-015.

Verification
REQ-034 Scan an=1110,1101,1011,0111 with seg 06,5B,4F,66, 20 cycles each -> value=16'h4321, digit_err=0, frame_valid=1.
REQ-035 Sweep the 16 glyphs on all digits, 20 cycles per step -> published nibble per digit equals glyph index 0..F.
REQ-036 Hold a digit 5 cycles then change -> no capture, mask unchanged, no frame.
REQ-037 seg=00 on digit 2, others valid -> value[11:8]=0, digit_err=4'b0100.
REQ-038 frame_ready=0 over two full scans -> value holds first frame, overrun=1; frame_ready=1 one cycle -> frame_valid=0, overrun=0.
REQ-039 rst_n low after two digits captured, then full scan -> all outputs 0 during reset; frame published only after all four digits recaptured; stale=1 after 65535 idle cycles.
